// File: rtl/conv_pkg.sv
// Shared constants and drain-FSM state type for the convolution result writer.
package conv_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int PARA_X     = 3;
  localparam int PARA_Y     = 3;
  localparam int ADDR_WIDTH = 16;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

endpackage

// File: rtl/conv_result_writer_tile_fifo.sv
// Register FIFO holding whole result tiles. A push is accepted while full
// provided the head is popped in the same cycle.
module tile_fifo #(
  parameter int WIDTH = 144,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Tile storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; contents are only observed
    // through head while count says the slot holds a valid tile.
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/conv_result_writer.sv
// Result writer for the float16 convolution array: buffers result tiles and
// serialises them element by element onto a valid/ready write port with
// output-feature-map addressing.
// Optional build macro CONV_RESULT_WRITER_RELU_EN: when defined, elements
// with the sign bit set are written as zero.
module conv_result_writer #(
  parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
  parameter int PARA_X     = conv_pkg::PARA_X,
  parameter int PARA_Y     = conv_pkg::PARA_Y,
  parameter int ADDR_WIDTH = conv_pkg::ADDR_WIDTH,
  parameter int FIFO_DEPTH = conv_pkg::FIFO_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [ADDR_WIDTH-1:0]               base_addr,
  input  logic [ADDR_WIDTH-1:0]               row_stride,
  input  logic [7:0]                          tiles_per_row,
  input  logic                                result_ready,
  input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0] result_buffer,
  output logic                                wr_valid,
  input  logic                                wr_ready,
  output logic [ADDR_WIDTH-1:0]               wr_addr,
  output logic [DATA_WIDTH-1:0]               wr_data,
  output logic                                tile_done,
  output logic                                busy,
  output logic                                overflow
);

  localparam int NUM_ELEM = PARA_X * PARA_Y;
  localparam int TILE_W   = NUM_ELEM * DATA_WIDTH;
  localparam int IDX_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam int COL_W    = (PARA_Y > 1) ? $clog2(PARA_Y) : 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

  conv_pkg::drain_state_e state, state_n;

  logic [TILE_W-1:0]     head_tile;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;

  logic [ADDR_WIDTH-1:0] row_stride_q;
  logic [7:0]            tiles_per_row_q;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] tile_base;
  logic [7:0]            tile_col;
  logic [IDX_W-1:0]      elem_idx;
  logic [COL_W-1:0]      col;
  logic [ADDR_WIDTH-1:0] row_off;     // r * row_stride, kept incrementally

  logic [DATA_WIDTH-1:0] elem;
  logic [DATA_WIDTH-1:0] elem_out;
  logic                  start_ok;
  logic                  xfer;
  logic                  last_elem;
  logic                  pop;
  logic                  next_nonempty;

  assign start_ok  = start && !busy && !result_ready;
  assign xfer      = (state == conv_pkg::DRAIN) && wr_ready;
  assign last_elem = (elem_idx == IDX_W'(NUM_ELEM - 1));
  assign pop       = xfer && last_elem;
  assign busy      = !fifo_empty;
  // Occupancy after the coming edge; lets the FSM enter DRAIN on the capture
  // edge itself and skip the bubble between queued tiles.
  assign next_nonempty = result_ready ||
                         !(fifo_empty || ((fifo_count == CNT_W'(1)) && pop));

  tile_fifo #(
    .WIDTH (TILE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tile_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (result_ready),
    .push_data (result_buffer),
    .pop       (pop),
    .head      (head_tile),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Select the current element of the head tile and apply optional ReLU.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    elem = '0;
    for (int k = 0; k < NUM_ELEM; k++) begin
      if (elem_idx == IDX_W'(k)) elem = head_tile[k*DATA_WIDTH +: DATA_WIDTH];
    end
`ifdef CONV_RESULT_WRITER_RELU_EN
    elem_out = elem[DATA_WIDTH-1] ? '0 : elem;
`else
    elem_out = elem;
`endif
  end

  // Drain FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= conv_pkg::IDLE;
    else      state <= state_n;
  end

  // Drain FSM next state and write-port outputs.
  always_comb begin
    state_n  = state;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    case (state)
      conv_pkg::IDLE: begin
        if (next_nonempty) state_n = conv_pkg::DRAIN;
      end
      conv_pkg::DRAIN: begin
        wr_valid = 1'b1;
        wr_addr  = tile_base + row_off + ADDR_WIDTH'(col);
        wr_data  = elem_out;
        if (!next_nonempty) state_n = conv_pkg::IDLE;
      end
      default: state_n = conv_pkg::IDLE;
    endcase
  end

  // Configuration, tile placement, element counters and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_stride_q    <= '0;
      tiles_per_row_q <= '0;
      row_base        <= '0;
      tile_base       <= '0;
      tile_col        <= '0;
      elem_idx        <= '0;
      col             <= '0;
      row_off         <= '0;
      tile_done       <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      tile_done <= pop;

      if (start_ok) begin
        row_stride_q    <= row_stride;
        tiles_per_row_q <= tiles_per_row;
        row_base        <= base_addr;
        tile_base       <= base_addr;
        tile_col        <= '0;
        overflow        <= 1'b0;
      end else if (result_ready && fifo_full && !pop) begin
        overflow <= 1'b1;
      end

      if (xfer) begin
        if (last_elem) begin
          elem_idx <= '0;
          col      <= '0;
          row_off  <= '0;
          if (tile_col == tiles_per_row_q - 8'd1) begin
            tile_col  <= '0;
            row_base  <= row_base + ADDR_WIDTH'(PARA_X) * row_stride_q;
            tile_base <= row_base + ADDR_WIDTH'(PARA_X) * row_stride_q;
          end else begin
            tile_col  <= tile_col + 8'd1;
            tile_base <= tile_base + ADDR_WIDTH'(PARA_Y);
          end
        end else begin
          elem_idx <= elem_idx + IDX_W'(1);
          if (col == COL_W'(PARA_Y - 1)) begin
            col     <= '0;
            row_off <= row_off + row_stride_q;
          end else begin
            col <= col + COL_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_result_writer.sv
// Self-checking bench for conv_result_writer: directed scenarios plus
// randomized traffic against a tile-level reference model.
module tb_conv_result_writer;

  localparam int DW = 16;
  localparam int PX = 3;
  localparam int PY = 3;
  localparam int NE = PX * PY;
  localparam int TW = NE * DW;
  localparam int FD = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   base_addr = '0;
  logic [15:0]   row_stride = '0;
  logic [7:0]    tiles_per_row = '0;
  logic          result_ready = 1'b0;
  logic [TW-1:0] result_buffer = '0;
  logic          wr_valid;
  logic          wr_ready = 1'b0;
  logic [15:0]   wr_addr;
  logic [15:0]   wr_data;
  logic          tile_done;
  logic          busy;
  logic          overflow;

  conv_result_writer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base_addr     (base_addr),
    .row_stride    (row_stride),
    .tiles_per_row (tiles_per_row),
    .result_ready  (result_ready),
    .result_buffer (result_buffer),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .tile_done     (tile_done),
    .busy          (busy),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (tile level) ----------------
  logic [TW-1:0] q_tile[$];
  int            q_idx[$];       // tile position since the accepted start
  int            m_elem = 0;
  int            m_tile_cnt = 0;
  logic [15:0]   m_base = '0;
  logic [15:0]   m_stride = '0;
  int            m_tpr = 1;
  logic          exp_td = 1'b0;
  logic          exp_ovf = 1'b0;

  // Observed write stream
  int            n_xfer = 0;
  int            cyc = 0;
  int            first_cyc = 0;
  int            last_cyc = 0;
  logic [15:0]   obs_addr[$];
  logic [15:0]   obs_data[$];

  function automatic logic [15:0] exp_addr(int t, int k);
    int tr = t / m_tpr;
    int tc = t % m_tpr;
    int r  = k / PY;
    int c  = k % PY;
    return 16'(int'(m_base) + (tr * PX + r) * int'(m_stride) + tc * PY + c);
  endfunction

  function automatic logic [15:0] exp_data(logic [TW-1:0] t, int k);
    logic [15:0] e = t[k*DW +: DW];
`ifdef CONV_RESULT_WRITER_RELU_EN
    if (e[15]) e = '0;
`endif
    return e;
  endfunction

  // Compare outputs with the model, then advance the model across the next edge.
  always @(negedge clk) begin
    logic exp_valid;
    logic pop_now;
    cyc++;
    if (!rst) begin
      check("rst_wr_valid", wr_valid, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_tile_done", tile_done, 0);
      check("rst_busy", busy, 0);
      check("rst_overflow", overflow, 0);
      q_tile.delete();
      q_idx.delete();
      m_elem = 0;
      m_tile_cnt = 0;
      exp_td = 1'b0;
      exp_ovf = 1'b0;
    end else begin
      exp_valid = (q_tile.size() != 0);
      check("wr_valid", wr_valid, exp_valid);
      check("busy", busy, exp_valid);
      check("tile_done", tile_done, exp_td);
      check("overflow", overflow, exp_ovf);
      if (exp_valid && wr_valid) begin
        check("wr_addr", wr_addr, exp_addr(q_idx[0], m_elem));
        check("wr_data", wr_data, exp_data(q_tile[0], m_elem));
      end
      if (wr_valid && wr_ready) begin
        if (n_xfer == 0) first_cyc = cyc;
        last_cyc = cyc;
        n_xfer++;
        obs_addr.push_back(wr_addr);
        obs_data.push_back(wr_data);
      end
      pop_now = exp_valid && wr_ready && (m_elem == NE - 1);
      exp_td = pop_now;
      if (exp_valid && wr_ready) m_elem = pop_now ? 0 : m_elem + 1;
      if (start && !exp_valid && !result_ready) begin
        m_base = base_addr;
        m_stride = row_stride;
        m_tpr = int'(tiles_per_row);
        m_tile_cnt = 0;
        exp_ovf = 1'b0;
      end
      if (pop_now) begin
        void'(q_tile.pop_front());
        void'(q_idx.pop_front());
      end
      if (result_ready) begin
        if (q_tile.size() < FD) begin
          q_tile.push_back(result_buffer);
          q_idx.push_back(m_tile_cnt);
          m_tile_cnt++;
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int rdy_mode = 0;   // 0: always 1, 1: 1,0,0 pattern, 2: random, 3: always 0
  int rdy_phase = 0;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       wr_ready = 1'b1;
      1: begin
        wr_ready = (rdy_phase % 3 == 0);
        rdy_phase++;
      end
      2:       wr_ready = ($urandom_range(0, 9) < 7);
      default: wr_ready = 1'b0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] b, input logic [15:0] s, input logic [7:0] t);
    base_addr = b;
    row_stride = s;
    tiles_per_row = t;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_tile(input logic [TW-1:0] t);
    result_buffer = t;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while ((q_tile.size() != 0 || busy) && n < limit) begin
      tick();
      n++;
    end
    check("drain_timeout", (n < limit), 1);
    tick();
    tick();
  endtask

  task automatic clear_obs();
    n_xfer = 0;
    obs_addr.delete();
    obs_data.delete();
  endtask

  function automatic logic [TW-1:0] rand_tile();
    logic [TW-1:0] t;
    for (int k = 0; k < NE; k++) t[k*DW +: DW] = 16'($urandom);
    return t;
  endfunction

  logic [TW-1:0] tile;
  logic [15:0]   exp_a [9];
  logic [15:0]   relu_exp [3];

  initial begin
    exp_a = '{16'h100, 16'h101, 16'h102, 16'h120, 16'h121, 16'h122,
              16'h140, 16'h141, 16'h142};
    #2 rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Single tile, ready held high
    rdy_mode = 0;
    do_start(16'h0100, 16'h0020, 8'd3);
    for (int k = 0; k < NE; k++) tile[k*DW +: DW] = 16'h3C00 + 16'(k * 16'h180);
    clear_obs();
    send_tile(tile);
    wait_drain(100);
    check("single_count", n_xfer, 9);
    for (int k = 0; k < NE; k++) begin
      check("single_addr", obs_addr[k], exp_a[k]);
      check("single_data", obs_data[k], 16'h3C00 + 16'(k * 16'h180));
    end

    // Back-pressure 1,0,0 pattern
    rdy_mode = 1;
    do_start(16'h0100, 16'h0020, 8'd3);
    clear_obs();
    send_tile(tile);
    wait_drain(200);
    check("bp_count", n_xfer, 9);
    for (int k = 0; k < NE; k++) check("bp_addr", obs_addr[k], exp_a[k]);

    // Three tiles, two per row band, no bubble
    rdy_mode = 0;
    do_start(16'h0100, 16'h0020, 8'd2);
    clear_obs();
    send_tile(rand_tile());
    send_tile(rand_tile());
    repeat (8) tick();
    send_tile(rand_tile());
    wait_drain(200);
    check("b2b_count", n_xfer, 27);
    check("b2b_span", last_cyc - first_cyc + 1, 27);
    check("b2b_base0", obs_addr[0], 16'h0100);
    check("b2b_base1", obs_addr[9], 16'h0103);
    check("b2b_base2", obs_addr[18], 16'h0160);

    // Overflow with write path blocked
    rdy_mode = 3;
    do_start(16'h0400, 16'h0010, 8'd4);
    clear_obs();
    send_tile(rand_tile());
    send_tile(rand_tile());
    send_tile(rand_tile());
    tick();
    check("ovf_set", overflow, 1);
    check("ovf_no_writes", n_xfer, 0);
    rdy_mode = 0;
    wait_drain(200);
    check("ovf_drain_count", n_xfer, 18);
    check("ovf_sticky", overflow, 1);
    do_start(16'h0000, 16'h0010, 8'd1);
    check("ovf_cleared", overflow, 0);

    // Reset in the middle of a tile
    do_start(16'h0100, 16'h0020, 8'd3);
    clear_obs();
    send_tile(rand_tile());
    for (int n = 0; n < 50 && n_xfer < 4; n++) tick();
    check("mid_writes", n_xfer, 4);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", wr_valid, 0);
    check("mid_rst_busy", busy, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    do_start(16'h0200, 16'h0010, 8'd2);
    clear_obs();
    send_tile(tile);
    wait_drain(100);
    check("post_rst_count", n_xfer, 9);
    check("post_rst_addr0", obs_addr[0], 16'h0200);
    check("post_rst_addr3", obs_addr[3], 16'h0210);

    // Sign handling
    tile = rand_tile();
    tile[0*DW +: DW] = 16'hBC00;
    tile[1*DW +: DW] = 16'h8000;
    tile[2*DW +: DW] = 16'h3C00;
`ifdef CONV_RESULT_WRITER_RELU_EN
    relu_exp = '{16'h0000, 16'h0000, 16'h3C00};
`else
    relu_exp = '{16'hBC00, 16'h8000, 16'h3C00};
`endif
    do_start(16'h0300, 16'h0008, 8'd1);
    clear_obs();
    send_tile(tile);
    wait_drain(100);
    for (int k = 0; k < 3; k++) check("relu_data", obs_data[k], relu_exp[k]);

    // Randomized traffic
    for (int round = 0; round < 3; round++) begin
      rdy_mode = 0;
      do_start(16'($urandom), 16'($urandom), 8'($urandom_range(1, 4)));
      rdy_mode = 2;
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 12)) tick();
        if ($urandom_range(0, 9) == 0)
          do_start(16'($urandom), 16'($urandom), 8'($urandom_range(1, 4)));
        send_tile(rand_tile());
      end
      rdy_mode = 0;
      wait_drain(1000);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
